// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit two's-complement add/sub, one CW-bit chunk per stage.
// Ports: clk, rst (async, active-high); in_valid/in_ready, a, b, cin, sub in;
//        out_valid/out_ready, sum, cout, ovf out. CW = WIDTH/STAGES.
// Optional: define PIPELINED_ADDSUB_SAT_EN to saturate sum on signed overflow.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // the whole pipe moves as one; only a held result blocks it
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;
  assign c0       = cin ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // operand bits still unconsumed on entry to this stage
    localparam int RI = WIDTH - k * CW;

    logic [RI-1:0] oa;
    logic [RI-1:0] ob;
    logic          ci;
    logic          iv;
    logic [CW:0]   t;

    if (k == 0) begin : g_src
      assign oa = a;
      assign ob = b_eff;
      assign ci = c0;
      assign iv = in_valid;
    end else begin : g_src
      assign oa = g_st[k-1].g_mid.a_q;
      assign ob = g_st[k-1].g_mid.b_q;
      assign ci = g_st[k-1].g_mid.c_q;
      assign iv = g_st[k-1].g_mid.v_q;
    end

    assign t = {1'b0, oa[CW-1:0]}
             + {1'b0, ob[CW-1:0]}
             + {{CW{1'b0}}, ci};

    if (k < STAGES - 1) begin : g_mid
      // skew regs hold only the chunks later stages still need
      logic [RI-CW-1:0]      a_q;
      logic [RI-CW-1:0]      b_q;
      logic [(k+1)*CW-1:0]   s_q;
      logic [(k+1)*CW-1:0]   s_n;
      logic                  c_q;
      logic                  v_q;

      if (k == 0) begin : g_cat
        assign s_n = t[CW-1:0];
      end else begin : g_cat
        assign s_n = {t[CW-1:0], g_st[k-1].g_mid.s_q};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (adv) begin
          a_q <= oa[RI-1:CW];
          b_q <= ob[RI-1:CW];
          s_q <= s_n;
          c_q <= t[CW];
          v_q <= iv;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] raw_n;
      logic [WIDTH-1:0] s_n;
      logic             o_n;
      logic [WIDTH-1:0] s_q;
      logic             c_q;
      logic             o_q;
      logic             v_q;

      if (k == 0) begin : g_cat
        assign raw_n = t[CW-1:0];
      end else begin : g_cat
        assign raw_n = {t[CW-1:0], g_st[k-1].g_mid.s_q};
      end

      // top chunk still carries the operand MSBs
      assign o_n = (oa[CW-1] == ob[CW-1])
                && (t[CW-1] != oa[CW-1]);

`ifdef PIPELINED_ADDSUB_SAT_EN
      assign s_n = !o_n     ? raw_n :
                   oa[CW-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                              {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign s_n = raw_n;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q <= '0;
          c_q <= 1'b0;
          o_q <= 1'b0;
          v_q <= 1'b0;
        end else if (adv) begin
          s_q <= s_n;
          c_q <= t[CW];
          o_q <= o_n;
          v_q <= iv;
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].g_last.v_q;
  assign sum       = g_st[STAGES-1].g_last.s_q;
  assign cout      = g_st[STAGES-1].g_last.c_q;
  assign ovf       = g_st[STAGES-1].g_last.o_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed vectors, arithmetic reference model, per-cycle checker.
// Target: pipelined_addsub at WIDTH=16, STAGES=4.
module tb_pipelined_addsub;

  localparam int W = 16;
  localparam int S = 4;
`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        lit;
    logic [15:0] ls;
    logic        lco;
    logic        lov;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  logic        lit_en = 1'b0;
  logic [15:0] lit_s  = '0;
  logic        lit_co = 1'b0;
  logic        lit_ov = 1'b0;
  bit          tog    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // plain integer arithmetic, no chunking
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb);
    exp_t e;
    int u, r, sx, sy;
    e = '0;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!sb) begin
      u = int'(x) + int'(y) + int'(ci);
      r = sx + sy + int'(ci);
      e.co = (u > 65535);
    end else begin
      u = int'(x) - int'(y) - int'(ci);
      r = sx - sy - int'(ci);
      e.co = (u >= 0);
    end
    e.s  = u[15:0];
    e.ov = (r > 32767) || (r < -32768);
    if (SAT && e.ov) e.s = x[15] ? 16'h8000 : 16'h7FFF;
    return e;
  endfunction

  bit          prev_stall = 1'b0;
  logic [15:0] prev_sum   = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_sum", sum, prev_sum);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("stray_out", out_valid, 0);
        end else begin
          e = q[0];
          chk("sum", sum, e.s);
          chk("cout", cout, e.co);
          chk("ovf", ovf, e.ov);
          if (e.lit) begin
            chk("lit_sum", sum, e.ls);
            chk("lit_cout", cout, e.lco);
            chk("lit_ovf", ovf, e.lov);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        e = model(a, b, cin, sub);
        e.lit = lit_en;
        e.ls  = lit_s;
        e.lco = lit_co;
        e.lov = lit_ov;
        q.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tog) out_ready = ~out_ready;
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic ci, input logic sb, input logic le,
                      input logic [15:0] ls, input logic lco, input logic lov);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    lit_en = le; lit_s = ls; lit_co = lco; lit_ov = lov;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", acc, 1);
    in_valid = 1'b0;
    lit_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", n < 60, 1);
  endtask

  task automatic latency(input string name);
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk);
      #1;
      chk(name, out_valid, j == 3);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ready_idle", in_ready, 1);

    send(16'h00FF, 16'h0001, 0, 0, 1, 16'h0100, 0, 0);
    latency("latency1");
    drain();

    send(16'hFFFF, 16'h0001, 0, 0, 1, 16'h0000, 1, 0);
    send(16'h7FFF, 16'h0001, 0, 0, 1, SAT ? 16'h7FFF : 16'h8000, 0, 1);
    send(16'h0005, 16'h0007, 0, 1, 1, 16'hFFFE, 0, 0);
    send(16'h8000, 16'h0001, 0, 1, 1, SAT ? 16'h8000 : 16'h7FFF, 1, 1);
    send(16'h0009, 16'h0003, 1, 1, 1, 16'h0005, 1, 0);
    drain();

    send(16'h1234, 16'h1111, 0, 0, 1, 16'h2345, 0, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send(16'h0003, 16'h0004, 1, 1, 1, 16'hFFFE, 0, 0);
    chk("gap_first", out_valid, 1);
    latency("gap");
    drain();

    out_ready = 1'b1;
    tog = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1)
        send(16'h1111, 16'h0F0F, 0, 0, 1, 16'h2020, 0, 0);
      else if (i == 7)
        send(16'h7777, 16'h0F0F, 0, 0, 1, SAT ? 16'h7FFF : 16'h8686, 0, 1);
      else
        send(16'(i * 16'h1111), 16'h0F0F, 0, 0, 0, 16'h0, 0, 0);
    end
    drain();
    tog = 1'b0;
    out_ready = 1'b1;

    send(16'h1111, 16'h2222, 0, 0, 0, 16'h0, 0, 0);
    send(16'h0101, 16'h0202, 0, 0, 0, 16'h0, 0, 0);
    send(16'h4000, 16'h0001, 0, 1, 0, 16'h0, 0, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle", out_valid, 0);
    end
    send(16'h0010, 16'h0020, 0, 0, 1, 16'h0030, 0, 0);
    latency("latency_post_rst");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the team's fixed 4-bit ripple-carry adder.
- WIDTH-bit operands are split into STAGES equal chunks, one chunk resolved per stage, with the inter-chunk carry registered between stages.
- Valid/ready handshake on both sides; full throughput (one op per cycle) when not stalled.
- Used in datapaths where a WIDTH-bit ripple chain misses timing.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of STAGES.
- STAGES, 4, pipeline depth and chunk count; chunk width CW = WIDTH/STAGES; 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = A+B+cin, 1 = A-B-cin.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of the MSB; for sub, 1 = no borrow.
- ovf  output  1  signed overflow.

Behaviour:
- Operand transform at capture:
  - b_eff = sub ? ~b : b.
  - c0 = cin ^ sub.
  - Hence sub=1, cin=0 gives A-B; sub=1, cin=1 gives A-B-1.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv (combinational). A beat is accepted when in_valid && in_ready.
- On adv, all stages shift by one simultaneously; a stage holding no beat carries valid=0 (bubble). When adv=0, every stage register holds.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff plus the carry registered from stage k-1 (stage 0 uses c0).
  - Registers that chunk's sum bits and its carry.
  - Operand chunks not yet consumed are carried forward in skew registers; completed sum chunks are carried forward until the output.
- Latency: a beat accepted at edge N appears at out_valid/sum at edge N+STAGES-1 when there is no stall (the last stage register is the output register). Each stall cycle adds one cycle.
- cout: carry out of the final chunk.
- ovf = (a_msb == b_eff_msb) && (sum_msb != a_msb), computed in the final stage from the carried MSBs.
- Outputs sum/cout/ovf/out_valid come directly from the final stage registers. They are stable while out_valid=1 and out_ready=0.
- Ordering: results leave in acceptance order; no beat is dropped or duplicated.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.
- Wrap-around: the sum is modulo 2^WIDTH (unless saturation is enabled, see Optional Feature).
- Reset: asynchronous; every valid bit, data register, sum, cout and ovf is cleared to 0 immediately. in_ready is 1 while rst=0 and out_valid=0.
- Reset mid-operation: all in-flight beats are discarded; no stale result appears after release.
- STAGES=1: a single registered WIDTH-bit adder with one-cycle latency.
- in_valid=0 inserts a bubble; a, b, cin and sub are ignored when no beat is accepted.

Optional Feature:
- Macro: PIPELINED_ADDSUB_SAT_EN.
- Defined: when ovf=1, sum saturates to the signed bound in the final stage:
  - 0111..1 if a_msb=0.
  - 1000..0 if a_msb=1.
  - ovf and cout still report the raw (pre-saturation) condition.
- Not defined: sum wraps modulo 2^WIDTH; no saturation logic is generated.

Test Plan (all at WIDTH=16, STAGES=4, out_ready=1 unless stated):
- Add a=0x00FF, b=0x0001, cin=0, sub=0 -> after 3 edges: sum=0x0100, cout=0, ovf=0 (carry crosses a chunk boundary).
- Add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; then a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1 (with SAT_EN: sum=0x7FFF, ovf=1).
- Sub a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0; sub a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1 (with SAT_EN: 0x8000); sub a=9, b=3, cin=1 -> sum=0x0005, cout=1.
- Stream 8 back-to-back beats a=i*0x1111, b=0x0F0F while out_ready toggles 1,0,1,0... -> all 8 sums are emitted in order, each correct; sum is held stable during stall cycles; in_ready=0 exactly when out_valid=1 and out_ready=0.
- in_valid pattern 1,0,0,1 -> two results separated by two bubble cycles; out_valid=0 in the gap.
- Assert rst for 1 cycle with 3 beats in flight -> out_valid=0 and sum=0 immediately; after release no result appears until a new beat has been accepted and traversed the pipeline.
